// File: rtl/crgu_div_ctrl.sv
// crgu_div_ctrl: owns div_factor of the APB clock/reset generator (hclk -> pclk).
// Requesters are served in round-robin order. A granted ratio change waits until
// the APB side is idle and pclk has just fallen. The requester is acknowledged
// once the new pclk ratio has had 2*div hclk cycles to settle.
//
// Ports:
//   hclk, hresetn  system clock, asynchronous active-low reset
//   req[NREQ]      per-requester change request (level, four-phase)
//   req_div        requested ratios, slice i = req_div[i*DIV_WID +: DIV_WID]
//   ack[NREQ]      per-requester acknowledge
//   err[NREQ]      ratio rejected (< 2), valid while the matching ack is high
//   apb_busy       APB bridge has a transfer in flight
//   pclk           divided clock from the generator, sampled as data
//   div_factor     ratio driven to the generator
//   hold           blocks new APB transfers while a switch is in progress
//   busy           controller is not idle
module crgu_div_ctrl #(
    parameter int unsigned DIV_WID = 4,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DIV_RST = 4
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DIV_WID-1:0]   req_div,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           err,
    input  logic                      apb_busy,
    input  logic                      pclk,
    output logic [DIV_WID-1:0]        div_factor,
    output logic                      hold,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = DIV_WID + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DRAIN,
        S_ALIGN,
        S_APPLY,
        S_SETTLE,
        S_ACK
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [DIV_WID-1:0]   new_div_q, new_div_d;
    logic [DIV_WID-1:0]   div_q, div_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic [NREQ-1:0]      err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 pclk_q;

    logic                 any_req_c;
    logic [IDX_W-1:0]     gnt_sel_c;
    logic [DIV_WID-1:0]   sel_div_c;
    logic [NREQ-1:0]      gnt_oh_c;
    logic                 pclk_fall_c;

    // Round-robin search: first set req bit from ptr_q upward, wrapping.
    always_comb begin
        int unsigned k;
        k         = 0;
        any_req_c = 1'b0;
        gnt_sel_c = ptr_q;
        sel_div_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr_q) + i) % NREQ;
            if (!any_req_c && req[k]) begin
                any_req_c = 1'b1;
                gnt_sel_c = IDX_W'(k);
                sel_div_c = req_div[k*DIV_WID +: DIV_WID];
            end
        end
    end

    assign gnt_oh_c    = NREQ'(1) << gnt_q;
    assign pclk_fall_c = pclk_q & ~pclk;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        new_div_d = new_div_q;
        div_d     = div_q;
        ack_d     = ack_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    gnt_d     = gnt_sel_c;
                    new_div_d = sel_div_c;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (new_div_q < DIV_WID'(2)) begin
                    // Ratio 0/1 would stop pclk: reject without touching the divider.
                    ack_d   = gnt_oh_c;
                    err_d   = gnt_oh_c;
                    state_d = S_ACK;
                end else if (new_div_q == div_q) begin
                    ack_d   = gnt_oh_c;
                    err_d   = '0;
                    state_d = S_ACK;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!apb_busy) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // div_factor is updated on the edge entering APPLY, right after
                // the observed pclk fall, so it changes while pclk is low.
                if (pclk_fall_c) begin
                    div_d   = new_div_q;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                cnt_d   = CNT_W'({new_div_q, 1'b0}) - CNT_W'(1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    ack_d   = gnt_oh_c;
                    err_d   = '0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (!req[gnt_q]) begin
                    ack_d   = '0;
                    err_d   = '0;
                    state_d = S_IDLE;
                    if (32'(gnt_q) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hold_d = (state_d == S_DRAIN) || (state_d == S_ALIGN) ||
                 (state_d == S_APPLY) || (state_d == S_SETTLE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            new_div_q <= '0;
            div_q     <= DIV_WID'(DIV_RST);
            ack_q     <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            pclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            new_div_q <= new_div_d;
            div_q     <= div_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            pclk_q    <= pclk;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign div_factor = div_q;
    assign hold       = hold_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_crgu_div_ctrl.sv
// Bench for crgu_div_ctrl: a transaction-level model predicts the outputs every
// cycle; directed tests add hand-computed literal expectations.
module tb_crgu_div_ctrl;

    localparam int unsigned DIV_WID = 4;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned DIV_RST = 4;

    logic                    hclk = 1'b0;
    logic                    hresetn;
    logic [NREQ-1:0]         req;
    logic [NREQ*DIV_WID-1:0] req_div;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         err;
    logic                    apb_busy;
    logic                    pclk;
    logic [DIV_WID-1:0]      div_factor;
    logic                    hold;
    logic                    busy;

    int errors = 0;
    int checks = 0;
    int hold_cyc = 0;

    always #5 hclk = ~hclk;

    crgu_div_ctrl #(.DIV_WID(DIV_WID), .NREQ(NREQ), .DIV_RST(DIV_RST)) dut (
        .hclk(hclk), .hresetn(hresetn), .req(req), .req_div(req_div),
        .ack(ack), .err(err), .apb_busy(apb_busy), .pclk(pclk),
        .div_factor(div_factor), .hold(hold), .busy(busy)
    );

    // Clock generator stand-in: pclk period = div_factor hclk cycles, high first half.
    int gen_cnt;
    function automatic int gen_next(input int c, input int d);
        return (c + 1 >= d) ? 0 : c + 1;
    endfunction
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            gen_cnt <= 0;
            pclk    <= 1'b0;
        end else begin
            gen_cnt <= gen_next(gen_cnt, int'(div_factor));
            pclk    <= (gen_next(gen_cnt, int'(div_factor)) < int'(div_factor) / 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NREQ-1:0]         exp_ack, exp_err;
    logic [DIV_WID-1:0]      exp_div;
    logic                    exp_hold, exp_busy;
    logic [NREQ-1:0]         s_req;
    logic [NREQ*DIV_WID-1:0] s_rdiv;
    logic                    s_apb, s_fall, last_pclk;
    bit                      abort;
    int                      m_ptr, m_cur;

    // One hclk edge as the controller sees it; reset aborts the transaction.
    task automatic tick();
        @(posedge hclk or negedge hresetn);
        if (!hresetn) begin
            abort = 1'b1;
            return;
        end
        s_req     = req;
        s_rdiv    = req_div;
        s_apb     = apb_busy;
        s_fall    = last_pclk && !pclk;
        last_pclk = pclk;
    endtask

    task automatic run_txn();
        int g, nd;
        bit rej;
        g = -1;
        for (int i = 0; i < NREQ; i++)
            if (g < 0 && s_req[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        nd = int'(s_rdiv[g*DIV_WID +: DIV_WID]);
        exp_busy = 1'b1;
        tick(); if (abort) return;
        rej = (nd < 2);
        if (!rej && nd != m_cur) begin
            exp_hold = 1'b1;
            do begin tick(); if (abort) return; end while (s_apb);
            do begin tick(); if (abort) return; end while (!s_fall);
            exp_div = DIV_WID'(nd);
            m_cur   = nd;
            tick(); if (abort) return;
            repeat (2 * nd) begin tick(); if (abort) return; end
            exp_hold = 1'b0;
        end
        exp_ack = NREQ'(1) << g;
        exp_err = rej ? (NREQ'(1) << g) : '0;
        do begin tick(); if (abort) return; end while (s_req[g]);
        exp_ack  = '0;
        exp_err  = '0;
        exp_busy = 1'b0;
        m_ptr    = (g + 1) % NREQ;
    endtask

    initial begin
        forever begin
            exp_ack = '0; exp_err = '0; exp_div = DIV_WID'(DIV_RST);
            exp_hold = 1'b0; exp_busy = 1'b0;
            m_ptr = 0; m_cur = DIV_RST; last_pclk = 1'b0; abort = 1'b0;
            wait (hresetn === 1'b1);
            while (!abort) begin
                tick();
                if (!abort && s_req != '0) run_txn();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge hclk) begin
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("err", 32'(err), 32'(exp_err));
        chk("div_factor", 32'(div_factor), 32'(exp_div));
        chk("hold", 32'(hold), 32'(exp_hold));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        if (hold === 1'b1) hold_cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input int d);
        req_div[i*DIV_WID +: DIV_WID] = DIV_WID'(d);
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int budget);
        int n;
        n = 0;
        while (ack[i] !== 1'b1 && n < budget) begin @(negedge hclk); n++; end
        if (ack[i] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack%0d_timeout got=0 exp=1 t=%0t", i, $time);
        end
    endtask

    task automatic wait_any_ack(input int budget);
        int n;
        n = 0;
        while (ack === '0 && n < budget) begin @(negedge hclk); n++; end
        if (ack === '0) begin
            checks++; errors++;
            $display("FAIL any_ack_timeout got=0 exp=nonzero t=%0t", $time);
        end
    endtask

    task automatic reset_pulse();
        @(negedge hclk); #2 hresetn = 1'b0; #1;
        chk("rst_div", 32'(div_factor), 32'd4);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge hclk); @(negedge hclk); #2 hresetn = 1'b1;
        @(negedge hclk);
    endtask

    task automatic clean_reset();
        req = '0; apb_busy = 1'b0;
        reset_pulse();
    endtask

    task automatic measure_period(output int per);
        int n;
        logic prev;
        n = 0; prev = pclk;
        while (n < 100) begin @(negedge hclk); n++; if (prev && !pclk) break; prev = pclk; end
        per = 0; prev = pclk;
        while (n < 100) begin @(negedge hclk); n++; per++; if (prev && !pclk) break; prev = pclk; end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int per;
        int dv[2];
        hresetn = 1'b1; req = '0; req_div = '0; apb_busy = 1'b0;
        #1 hresetn = 1'b0;
        clean_reset();

        // 1: 4 -> 6 change
        hold_cyc = 0;
        set_req(0, 6);
        wait_ack(0, 200);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_div", 32'(div_factor), 32'd6);
        chk("t1_hold_len", 32'(hold_cyc >= 15), 32'd1);
        req[0] = 1'b0;
        @(negedge hclk); @(negedge hclk);
        chk("t1_idle", 32'(busy), 32'd0);
        measure_period(per);
        chk("t1_pclk_period", 32'(per), 32'd6);

        // 2: rejected ratios 1 and 0
        dv[0] = 1; dv[1] = 0;
        for (int k = 0; k < 2; k++) begin
            clean_reset();
            hold_cyc = 0;
            set_req(1, dv[k]);
            @(negedge hclk);
            chk("t2_ack_n", 32'(ack), 32'h0);
            chk("t2_busy_n", 32'(busy), 32'd1);
            @(negedge hclk);
            chk("t2_ack_n1", 32'(ack), 32'h2);
            chk("t2_err_n1", 32'(err), 32'h2);
            chk("t2_div", 32'(div_factor), 32'd4);
            req[1] = 1'b0;
            @(negedge hclk); @(negedge hclk);
            chk("t2_no_hold", 32'(hold_cyc), 32'd0);
        end

        // 3: no-op request equal to current ratio
        clean_reset();
        hold_cyc = 0;
        set_req(0, 4);
        @(negedge hclk); @(negedge hclk);
        chk("t3_ack", 32'(ack), 32'h1);
        chk("t3_err", 32'(err), 32'h0);
        req[0] = 1'b0;
        @(negedge hclk); @(negedge hclk);
        chk("t3_no_hold", 32'(hold_cyc), 32'd0);

        // 4: round-robin between simultaneous requests
        clean_reset();
        set_req(0, 8); set_req(1, 2);
        wait_any_ack(200);
        chk("t4_first", 32'(ack), 32'h1);
        chk("t4_div8", 32'(div_factor), 32'd8);
        req[0] = 1'b0;
        wait_ack(1, 200);
        chk("t4_second", 32'(ack), 32'h2);
        chk("t4_div2", 32'(div_factor), 32'd2);
        req[1] = 1'b0;
        @(negedge hclk); @(negedge hclk);
        set_req(0, 2);                       // no-op: moves pointer past requester 0
        wait_ack(0, 20);
        req[0] = 1'b0;
        @(negedge hclk); @(negedge hclk);
        set_req(0, 4); set_req(1, 6);
        wait_any_ack(200);
        chk("t4_rr_first", 32'(ack), 32'h2);
        chk("t4_div6", 32'(div_factor), 32'd6);
        req[1] = 1'b0;
        wait_ack(0, 200);
        chk("t4_div4", 32'(div_factor), 32'd4);
        req[0] = 1'b0;
        @(negedge hclk); @(negedge hclk);

        // 5: APB busy holds the sequence in DRAIN
        clean_reset();
        apb_busy = 1'b1;
        set_req(0, 8);
        for (int n = 0; n < 10 && hold !== 1'b1; n++) @(negedge hclk);
        repeat (20) @(negedge hclk);
        chk("t5_hold", 32'(hold), 32'd1);
        chk("t5_div", 32'(div_factor), 32'd4);
        chk("t5_busy", 32'(busy), 32'd1);
        apb_busy = 1'b0;
        wait_ack(0, 100);
        chk("t5_div8", 32'(div_factor), 32'd8);
        req[0] = 1'b0;
        @(negedge hclk); @(negedge hclk);

        // 6: reset during SETTLE, held request re-arbitrated afterwards
        clean_reset();
        set_req(0, 10);
        for (int n = 0; n < 100 && div_factor !== 4'd10; n++) @(negedge hclk);
        repeat (3) @(negedge hclk);
        chk("t6_settle_hold", 32'(hold), 32'd1);
        reset_pulse();
        wait_ack(0, 200);
        chk("t6_ack", 32'(ack), 32'h1);
        chk("t6_div10", 32'(div_factor), 32'd10);
        req[0] = 1'b0;
        repeat (3) @(negedge hclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
